// File: rtl/mac_vec.sv
// mac_vec: LANES parallel unsigned multiply-accumulate lanes over a VEC_LEN-long vector.
// Latency: 2 rising edges from accept to Cout update (product register, then accumulate).
// Backpressure: Ready drops once VEC_LEN sets are accepted; held low until Clr or rst.
// Optional build macro MAC_SAT_EN: saturating accumulators with sticky per-lane Ovf.
module mac_vec #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int VEC_LEN    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         En,
    input  logic                         Clr,
    input  logic [LANES*DATA_WIDTH-1:0]  Ain,
    input  logic [LANES*DATA_WIDTH-1:0]  Bin,
    output logic [LANES*ACC_WIDTH-1:0]   Cout,
    output logic                         Ready,
    output logic                         Done,
    output logic [LANES-1:0]             Ovf
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
`ifdef MAC_SAT_EN
    // One extra bit keeps the carry out so an overflowing sum can be detected.
    localparam int SUM_W = ACC_WIDTH + 1;
`else
    localparam int SUM_W = ACC_WIDTH;
`endif

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_s1_vld;
    logic                 r_s1_last;
    logic                 r_done;
    logic [PROD_W-1:0]    r_prod    [LANES];
    logic [ACC_WIDTH-1:0] r_acc     [LANES];
    logic [PROD_W-1:0]    w_prod    [LANES];
    logic [SUM_W-1:0]     w_sum     [LANES];
    logic [ACC_WIDTH-1:0] w_acc_nxt [LANES];
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last_accept;

    // Clr wins over En, so a set presented alongside Clr is never taken.
    assign w_accept      = En && w_ready && !Clr;
    assign w_last_accept = w_accept && (r_cnt == LAST_IDX);

    // State register: rst forces the accepting state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: fill up on the last accepted set, reopen only on Clr.
    always_comb begin
        w_state_nxt = r_state;
        if (Clr) begin
            w_state_nxt = ST_ACC;
        end else if (r_state == ST_ACC && w_last_accept) begin
            w_state_nxt = ST_FULL;
        end
    end

    // Output decode: accept operands only while the vector is not yet full.
    always_comb begin
        w_ready = (r_state == ST_ACC);
    end

    // Per-lane product and next accumulator value (wrap or clamp).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = {{DATA_WIDTH{1'b0}}, Ain[i*DATA_WIDTH +: DATA_WIDTH]}
                      * {{DATA_WIDTH{1'b0}}, Bin[i*DATA_WIDTH +: DATA_WIDTH]};
            w_sum[i]  = {{(SUM_W-ACC_WIDTH){1'b0}}, r_acc[i]}
                      + {{(SUM_W-PROD_W){1'b0}}, r_prod[i]};
`ifdef MAC_SAT_EN
            w_acc_nxt[i] = w_sum[i][ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[i][ACC_WIDTH-1:0];
`else
            w_acc_nxt[i] = w_sum[i];
`endif
        end
    end

    // Datapath: stage 1 captures products, stage 2 accumulates; Clr behaves like rst here,
    // which also drops any product still sitting in stage 1.
    always_ff @(posedge clk) begin
        if (rst || Clr) begin
            r_cnt     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
                r_acc[i]  <= '0;
            end
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_last <= w_last_accept;
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
            if (r_s1_vld) begin
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= w_acc_nxt[i];
                end
                if (r_s1_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

`ifdef MAC_SAT_EN
    logic [LANES-1:0] r_ovf;

    // Sticky overflow: set by any clamped accumulate, cleared only by Clr or rst.
    always_ff @(posedge clk) begin
        if (rst || Clr) begin
            r_ovf <= '0;
        end else if (r_s1_vld) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_sum[i][ACC_WIDTH]) begin
                    r_ovf[i] <= 1'b1;
                end
            end
        end
    end

    assign Ovf = r_ovf;
`else
    assign Ovf = '0;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_cout
        assign Cout[g*ACC_WIDTH +: ACC_WIDTH] = r_acc[g];
    end

    assign Ready = w_ready;
    assign Done  = r_done;

endmodule
